// File: rtl/march_cminus_sequencer.sv
// March C- sequencer: steps an external address counter through the six March C- elements
// on a single-port SRAM, compares read data one cycle later and latches the first failure.
module march_cminus_sequencer #(
  parameter int ARRAY_SIZE = 16,
  parameter int ADDR_WIDTH = $clog2(ARRAY_SIZE),
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  gen_en,
  output logic                  gen_clr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_CHECK
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ARRAY_SIZE - 1);
  localparam logic [DATA_WIDTH-1:0] BG0 = '0;
  localparam logic [DATA_WIDTH-1:0] BG1 = '1;

  state_t state;
  logic   phase;

  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] exp_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [2:0]            elem_p0;

  logic in_march, two_slot, rd_strobe, last_step;

  function automatic logic [DATA_WIDTH-1:0] read_bg(input state_t s);
    return (s == S_M2 || s == S_M4) ? BG1 : BG0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] write_bg(input state_t s);
    return (s == S_M1 || s == S_M3) ? BG1 : BG0;
  endfunction

  function automatic logic [2:0] elem_num(input state_t s);
    case (s)
      S_M1:    return 3'd1;
      S_M2:    return 3'd2;
      S_M3:    return 3'd3;
      S_M4:    return 3'd4;
      S_M5:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic state_t next_elem(input state_t s);
    case (s)
      S_M0:    return S_M1;
      S_M1:    return S_M2;
      S_M2:    return S_M3;
      S_M3:    return S_M4;
      S_M4:    return S_M5;
      S_M5:    return S_CHECK;
      default: return S_IDLE;
    endcase
  endfunction

  // Strobes decode from registered state only; the address tracks the counter directly.
  always_comb begin
    in_march  = (state inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5});
    two_slot  = (state inside {S_M1, S_M2, S_M3, S_M4});
    busy      = (state != S_IDLE);
    gen_clr   = (state == S_INIT);
    mem_cs    = in_march;
    mem_we    = (state == S_M0) || (two_slot && phase);
    gen_en    = (state == S_M0) || (state == S_M5) || (two_slot && phase);
    mem_wdata = mem_we ? write_bg(state) : BG0;
    mem_addr  = '0;
    if (state == S_M3 || state == S_M4)
      mem_addr = LAST_ADDR - addr_in;
    else if (in_march)
      mem_addr = addr_in;
    rd_strobe = mem_cs && !mem_we;
    last_step = gen_en && (addr_in == LAST_ADDR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      phase     <= 1'b0;
      vld_p0    <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else begin
      vld_p0 <= rd_strobe;
      if (vld_p0 && (mem_rdata != exp_p0) && !fail) begin
        fail      <= 1'b1;
        fail_addr <= addr_p0;
        fail_elem <= elem_p0;
      end
      case (state)
        S_IDLE: if (start) begin
          state     <= S_INIT;
          done      <= 1'b0;
          fail      <= 1'b0;
          fail_addr <= '0;
          fail_elem <= '0;
        end
        S_INIT: begin
          state <= S_M0;
          phase <= 1'b0;
        end
        S_M0, S_M5: if (last_step) state <= next_elem(state);
        S_M1, S_M2, S_M3, S_M4: begin
          phase <= ~phase;
          if (last_step) state <= next_elem(state);
        end
        S_CHECK: begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // p0: capture what each read should return; compared against mem_rdata next cycle
  always_ff @(posedge clk) begin
    if (rd_strobe) begin
      exp_p0  <= read_bg(state);
      addr_p0 <= mem_addr;
      elem_p0 <= elem_num(state);
    end
  end

endmodule

// File: tb/tb_march_cminus_sequencer.sv
// Directed bench: March C- sequencer driving a behavioural address counter and SRAM
// (optionally with bit 3 of address 5 stuck at 0).
module tb_march_cminus_sequencer;
  localparam int N  = 16;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          tb_clk = 1'b0;
  logic          rst, start;
  logic [AW-1:0] addr_in;
  logic          gen_en, gen_clr, mem_cs, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;

  always #5 tb_clk = ~tb_clk;

  march_cminus_sequencer #(.ARRAY_SIZE(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(tb_clk), .rst(rst), .start(start), .addr_in(addr_in),
    .gen_en(gen_en), .gen_clr(gen_clr), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr), .fail_elem(fail_elem)
  );

  // address counter: synchronous clear, wraps N-1 -> 0
  always @(posedge tb_clk) begin
    if (gen_clr) addr_in <= '0;
    else if (gen_en) addr_in <= (addr_in == AW'(N - 1)) ? '0 : addr_in + 1'b1;
  end

  logic [DW-1:0] mem [N];
  logic          fault_on;
  always @(posedge tb_clk) begin
    if (mem_cs) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= (fault_on && mem_addr == AW'(5)) ? (mem[mem_addr] & 8'hF7) : mem[mem_addr];
    end
  end

  int busy_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  logic [AW-1:0] log_addr [256];
  logic          log_we   [256];
  logic          log_gen  [256];
  always @(posedge tb_clk) begin
    if (busy) begin
      busy_cnt <= busy_cnt + 1;
      log_addr[busy_cnt[7:0]] <= mem_addr;
      log_we[busy_cnt[7:0]]   <= mem_cs && mem_we;
      log_gen[busy_cnt[7:0]]  <= gen_en;
    end
    if (mem_cs && mem_we)  wr_cnt <= wr_cnt + 1;
    if (mem_cs && !mem_we) rd_cnt <= rd_cnt + 1;
  end

  int cmps = 0, errs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_test(input bit repulse, input bit chk_clear,
                          output int nbusy, output int nwr, output int nrd, output int base);
    int w0, r0;
    bit seen;
    base = busy_cnt; w0 = wr_cnt; r0 = rd_cnt;
    seen = 1'b0;
    @(negedge tb_clk) start = 1'b1;
    @(negedge tb_clk) start = 1'b0;
    if (chk_clear) begin
      check("clear_done", 32'(done), 32'd0);
      check("clear_fail", 32'(fail), 32'd0);
      check("clear_fail_addr", 32'(fail_addr), 32'd0);
      check("clear_fail_elem", 32'(fail_elem), 32'd0);
      check("clear_busy", 32'(busy), 32'd1);
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge tb_clk);
      start = (repulse && c == 19);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("run_completes", 32'(seen), 32'd1);
    nbusy = busy_cnt - base;
    nwr   = wr_cnt - w0;
    nrd   = rd_cnt - r0;
  endtask

  int nb, nw, nr, base, idx;

  initial begin
    rst = 1'b0; start = 1'b0; fault_on = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_mem_cs", 32'(mem_cs), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_gen_en", 32'(gen_en), 32'd0);
    check("rst_gen_clr", 32'(gen_clr), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_fail_addr", 32'(fail_addr), 32'd0);
    check("rst_fail_elem", 32'(fail_elem), 32'd0);
    #10 rst = 1'b0;
    repeat (3) @(negedge tb_clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_mem_cs", 32'(mem_cs), 32'd0);

    // clean run
    run_test(1'b0, 1'b0, nb, nw, nr, base);
    check("clean_busy_cycles", 32'(nb), 32'd162);
    check("clean_writes", 32'(nw), 32'd80);
    check("clean_reads", 32'(nr), 32'd80);
    check("clean_done", 32'(done), 32'd1);
    check("clean_fail", 32'(fail), 32'd0);
    check("clean_busy_low", 32'(busy), 32'd0);
    for (int k = 0; k < 32; k++) begin
      idx = (base + 81 + k) % 256;
      check($sformatf("m3_addr_%0d", k), 32'(log_addr[idx]), 32'(15 - k / 2));
      check($sformatf("m3_we_%0d", k), 32'(log_we[idx]), 32'(k % 2));
      check($sformatf("m3_gen_en_%0d", k), 32'(log_gen[idx]), 32'(k % 2));
    end
    idx = (base + 113) % 256;
    check("m4_first_addr", 32'(log_addr[idx]), 32'd15);
    check("m4_first_is_read", 32'(log_we[idx]), 32'd0);

    // stuck-at fault, with an ignored start re-pulse mid-run
    fault_on = 1'b1;
    run_test(1'b1, 1'b0, nb, nw, nr, base);
    check("fault_busy_cycles", 32'(nb), 32'd162);
    check("fault_done", 32'(done), 32'd1);
    check("fault_fail", 32'(fail), 32'd1);
    check("fault_fail_addr", 32'(fail_addr), 32'd5);
    check("fault_fail_elem", 32'(fail_elem), 32'd2);

    // new start after a failing run clears status on the accepting edge
    fault_on = 1'b0;
    run_test(1'b0, 1'b1, nb, nw, nr, base);
    check("rerun_busy_cycles", 32'(nb), 32'd162);
    check("rerun_fail", 32'(fail), 32'd0);

    // reset in the middle of M2
    @(negedge tb_clk) start = 1'b1;
    @(negedge tb_clk) start = 1'b0;
    repeat (60) @(negedge tb_clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_cs", 32'(mem_cs), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_fail", 32'(fail), 32'd0);
    #10 rst = 1'b0;
    @(negedge tb_clk);
    run_test(1'b0, 1'b0, nb, nw, nr, base);
    check("post_abort_busy_cycles", 32'(nb), 32'd162);
    check("post_abort_writes", 32'(nw), 32'd80);
    check("post_abort_done", 32'(done), 32'd1);
    check("post_abort_fail", 32'(fail), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
